rom_ctrl_scan_fsm: RTL and testbench
====================================

Name: rom_ctrl_scan_fsm

Overview:
Parametrised ROM integrity scanner and the next generation of the ROM checker FSM. It contains its own address counter and its own word-serial digest comparator, and supports configurable data width. It streams the low ROM region to KMAC and captures the top TopCount words as the expected digest. It then compares the KMAC result word-by-word and reports done/good to pwrmgr/keymgr glue. It sits between the ROM mux, KMAC and the rom_ctrl CSR block.

Parameters:
RomDepth, 16, ROM words; must be > TopCount.
TopCount, 8, digest words stored at top of ROM; >= 1.
DataWidth, 32, ROM word / digest word width in bits.

Ports:
clk_i  input  1  clock.
rst_i  input  1  synchronous active-high reset.
rom_req_o  output  1  ROM read request; data returns on rom_data_i exactly 1 cycle later.
rom_addr_o  output  AW=$clog2(RomDepth)  ROM read address.
rom_data_i  input  DataWidth  ROM read data.
rom_select_o  output  1  1 while the FSM owns the ROM mux.
kmac_vld_o  output  1  ROM word valid to KMAC.
kmac_data_o  output  DataWidth  ROM word to KMAC.
kmac_last_o  output  1  current word is the last low-region word.
kmac_rdy_i  input  1  KMAC accepts word.
kmac_done_i  input  1  single-cycle digest-ready pulse.
kmac_err_i  input  1  KMAC error, sampled with kmac_done_i.
kmac_digest_i  input  TopCount*DataWidth  digest, word 0 in LSBs, valid with kmac_done_i.
exp_digest_o  output  DataWidth  captured top word (CSR snoop).
exp_digest_vld_o  output  1  exp_digest_o valid this cycle.
exp_digest_idx_o  output  TAW=max(1,$clog2(TopCount))  word index.
rescan_req_i  input  1  restart request (see Optional Feature).
busy_o  output  1  scan in progress.
done_o  output  1  check complete.
good_o  output  1  digest matched; meaningful only with done_o.
alert_o  output  1  fatal alert, sticky.

Behaviour:
- Reset: state=ReadLow, counters 0. All outputs 0 except rom_select_o=1 and busy_o=1. A mid-scan reset aborts the scan immediately; no KMAC last is sent.
- TopStart = RomDepth-TopCount.
- Single-entry KMAC buffer. In ReadLow, rom_req_o=1 when the buffer is empty, or when it is full and kmac_vld_o&kmac_rdy_i.
- The returned word loads the buffer the next cycle and sets kmac_vld_o. The buffer holds until kmac_rdy_i; data is never dropped or reordered.
- kmac_last_o=1 when the buffered word is address TopStart-1.
- ReadLow -> ReadHigh when the last word is accepted. No requests are issued for low addresses after TopStart-1.
- ReadHigh: one request per cycle, addresses TopStart..RomDepth-1.
  - Each returned word is stored in the expected-digest register at idx=addr-TopStart.
  - exp_digest_vld_o pulses for 1 cycle with that idx.
  - rom_done is set when idx TopCount-1 is captured.
- KMAC digest is latched on kmac_done_i.
- ReadHigh transitions:
  - rom_done only -> WaitKmac.
  - kmac_done_i only -> WaitRom.
  - Both in the same cycle -> Compare.
- WaitKmac -> Compare on kmac_done_i. WaitRom -> Compare on rom_done.
- kmac_err_i=1 with kmac_done_i -> Invalid.
- Compare: 1 word per cycle, idx 0..TopCount-1; any mismatch sets a sticky flag. After idx TopCount-1 -> Done, next cycle. Compare latency is exactly TopCount cycles.
- Done: done_o=1, good_o=!mismatch, rom_select_o=0, busy_o=0.
- Consistency violations -> Invalid next cycle:
  - kmac_done_i outside ReadHigh/WaitKmac.
  - A second kmac_done_i.
  - kmac_rdy_i&kmac_vld_o outside ReadLow.
  - Any unencoded state.
- Invalid: terminal; alert_o=1 from the next cycle, sticky until reset. done_o=0, good_o=0, rom_req_o=0, rom_select_o=1.
- State encoding is sparse (Hamming distance >= 3); any illegal encoding is treated as Invalid.

Optional Feature:
ROM_CTRL_SCAN_RESCAN_EN.
- Defined:
  - rescan_req_i=1 in Done -> ReadLow next cycle.
  - Clears counters, mismatch flag, captured digests and done_o/good_o; rom_select_o=1.
  - rescan_req_i in any other state is ignored.
- Undefined: rescan_req_i is ignored and left unused; Done is terminal.

Test Plan:
- RomDepth=16, TopCount=8, kmac_rdy_i=1 always, top words equal the KMAC digest, kmac_done_i 3 cycles after last:
  - 8 KMAC transfers; last on address 7.
  - exp_digest_vld_o pulses idx 0..7.
  - done_o=1, good_o=1, rom_select_o=0.
- Same setup, KMAC digest word 5 differs -> done_o=1, good_o=0, alert_o=0.
- kmac_rdy_i toggling 1-in-3 -> kmac_data_o holds stable while kmac_vld_o&!kmac_rdy_i; all 8 words sent in order 0..7.
- Race cases:
  - kmac_done_i in the same cycle as idx 7 capture -> WaitKmac/WaitRom skipped; Compare lasts 8 cycles.
  - kmac_done_i before ROM finishes -> WaitRom path.
- Fault cases:
  - kmac_done_i during ReadLow -> alert_o=1 next cycle, stays 1, done_o=0.
  - kmac_err_i=1 -> same response.
- With ROM_CTRL_SCAN_RESCAN_EN: rescan_req_i in Done -> rom_addr_o restarts at 0, done_o=0, second full pass completes good.
- Without ROM_CTRL_SCAN_RESCAN_EN: same stimulus -> no change.

Source files
------------

// File: rtl/rom_ctrl_scan_fsm.sv
// ROM integrity scanner: streams the low ROM region to KMAC, captures the top words as the
// expected digest and compares them against the KMAC result. Rescan from Done: ROM_CTRL_SCAN_RESCAN_EN.
module rom_ctrl_scan_fsm #(
    parameter int RomDepth  = 16,
    parameter int TopCount  = 8,
    parameter int DataWidth = 32,
    localparam int AW  = $clog2(RomDepth),
    localparam int TAW = (TopCount > 1) ? $clog2(TopCount) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    output logic                            rom_req_o,
    output logic [AW-1:0]                   rom_addr_o,
    input  logic [DataWidth-1:0]            rom_data_i,
    output logic                            rom_select_o,
    output logic                            kmac_vld_o,
    output logic [DataWidth-1:0]            kmac_data_o,
    output logic                            kmac_last_o,
    input  logic                            kmac_rdy_i,
    input  logic                            kmac_done_i,
    input  logic                            kmac_err_i,
    input  logic [TopCount*DataWidth-1:0]   kmac_digest_i,
    output logic [DataWidth-1:0]            exp_digest_o,
    output logic                            exp_digest_vld_o,
    output logic [TAW-1:0]                  exp_digest_idx_o,
    input  logic                            rescan_req_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            good_o,
    output logic                            alert_o
);

    localparam int              TopStart    = RomDepth - TopCount;
    localparam logic [AW:0]     CntTopStart = (AW+1)'(TopStart);
    localparam logic [AW:0]     CntEnd      = (AW+1)'(RomDepth);
    localparam logic [AW-1:0]   LastLowAddr = AW'(TopStart - 1);
    localparam logic [AW-1:0]   TopAddr     = AW'(TopStart);
    localparam logic [TAW-1:0]  LastIdx     = TAW'(TopCount - 1);

    // Codes are pairwise Hamming distance >= 3; anything else decodes to Invalid.
    typedef enum logic [5:0] {
        ReadLow  = 6'b100110,
        ReadHigh = 6'b010101,
        WaitKmac = 6'b001011,
        WaitRom  = 6'b110011,
        Compare  = 6'b101101,
        Done     = 6'b011110,
        Invalid  = 6'b111000
    } state_e;

    state_e                              state_q, state_d;
    logic                                run_q, alert_q, rescan;
    logic [AW:0]                         cnt_q;
    logic                                pend_q;
    logic [AW-1:0]                       pend_addr_q;
    logic                                buf_vld_q, buf_last_q;
    logic [DataWidth-1:0]                buf_q;
    logic [TopCount-1:0][DataWidth-1:0]  exp_q, dig_q;
    logic [TAW-1:0]                      cmp_idx_q;
    logic                                mismatch_q;

    logic           in_low, in_fetch_hi, kmac_acc, cap_now, cap_last;
    logic [TAW-1:0] cap_idx;

    assign in_low      = (state_q == ReadLow);
    assign in_fetch_hi = (state_q == ReadHigh) || (state_q == WaitRom);
    assign kmac_acc    = buf_vld_q && kmac_rdy_i;
    assign cap_now     = in_fetch_hi && pend_q;
    assign cap_idx     = TAW'(pend_addr_q - TopAddr);
    assign cap_last    = cap_now && (cap_idx == LastIdx);

    // An in-flight read counts as occupying the single buffer slot, so a word can never
    // arrive while the previous one is still waiting for KMAC.
    always_comb begin
        rom_req_o = 1'b0;
        if (in_low) begin
            rom_req_o = run_q && (cnt_q < CntTopStart) && !pend_q && (!buf_vld_q || kmac_acc);
        end else if (in_fetch_hi) begin
            rom_req_o = (cnt_q < CntEnd);
        end
    end

    always_comb begin
        state_d = state_q;
        rescan  = 1'b0;
        case (state_q)
            ReadLow:  if (kmac_acc && buf_last_q) state_d = ReadHigh;
            ReadHigh: begin
                if (cap_last && kmac_done_i) state_d = Compare;
                else if (cap_last)           state_d = WaitKmac;
                else if (kmac_done_i)        state_d = WaitRom;
            end
            WaitKmac: if (kmac_done_i) state_d = Compare;
            WaitRom:  if (cap_last) state_d = Compare;
            Compare:  if (cmp_idx_q == LastIdx) state_d = Done;
            Done: begin
`ifdef ROM_CTRL_SCAN_RESCAN_EN
                if (rescan_req_i) begin
                    state_d = ReadLow;
                    rescan  = 1'b1;
                end
`endif
            end
            Invalid:  state_d = Invalid;
            default:  state_d = Invalid;
        endcase
        if (kmac_done_i && (kmac_err_i || !((state_q == ReadHigh) || (state_q == WaitKmac)))) begin
            state_d = Invalid;
        end
        if (kmac_acc && !in_low) begin
            state_d = Invalid;
        end
    end

`ifndef ROM_CTRL_SCAN_RESCAN_EN
    logic unused_rescan_req;
    assign unused_rescan_req = rescan_req_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ReadLow;
            run_q   <= 1'b0;
            alert_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            alert_q <= alert_q | (state_d == Invalid);
        end

        if (rst_i || rescan) begin
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            buf_vld_q   <= 1'b0;
            buf_last_q  <= 1'b0;
            buf_q       <= '0;
            exp_q       <= '0;
            dig_q       <= '0;
            cmp_idx_q   <= '0;
            mismatch_q  <= 1'b0;
        end else begin
            pend_q <= rom_req_o;
            if (rom_req_o) begin
                pend_addr_q <= rom_addr_o;
                cnt_q       <= cnt_q + 1'b1;
            end
            if (in_low && pend_q) begin
                buf_q      <= rom_data_i;
                buf_last_q <= (pend_addr_q == LastLowAddr);
                buf_vld_q  <= 1'b1;
            end else if (kmac_acc || !in_low) begin
                buf_vld_q  <= 1'b0;
            end
            if (cap_now) exp_q[cap_idx] <= rom_data_i;
            if (kmac_done_i) dig_q <= kmac_digest_i;
            if (state_q == Compare) begin
                if (exp_q[cmp_idx_q] != dig_q[cmp_idx_q]) mismatch_q <= 1'b1;
                cmp_idx_q <= cmp_idx_q + 1'b1;
            end
        end
    end

    assign rom_addr_o       = cnt_q[AW-1:0];
    assign rom_select_o     = (state_q != Done);
    assign kmac_vld_o       = buf_vld_q;
    assign kmac_data_o      = buf_q;
    assign kmac_last_o      = buf_vld_q && buf_last_q;
    assign exp_digest_vld_o = cap_now;
    assign exp_digest_idx_o = cap_now ? cap_idx : '0;
    assign exp_digest_o     = cap_now ? rom_data_i : '0;
    assign busy_o           = (state_q != Done) && (state_q != Invalid);
    assign done_o           = (state_q == Done);
    assign good_o           = (state_q == Done) && !mismatch_q;
    assign alert_o          = alert_q;

endmodule

// File: tb/tb_rom_ctrl_scan_fsm.sv
// Bench for rom_ctrl_scan_fsm: ROM model plus KMAC/capture scoreboards, one task per scenario.
module tb_rom_ctrl_scan_fsm;

    localparam int RomDepth = 16;
    localparam int TopCount = 8;
    localparam int DW       = 32;
    localparam int AW       = 4;
    localparam int TAW      = 3;
    localparam int TopStart = RomDepth - TopCount;

    logic                      clk_i = 1'b0;
    logic                      rst_i = 1'b1;
    logic                      rom_req_o, rom_select_o;
    logic [AW-1:0]             rom_addr_o;
    logic [DW-1:0]             rom_data_i = '0;
    logic                      kmac_vld_o, kmac_last_o;
    logic [DW-1:0]             kmac_data_o;
    logic                      kmac_rdy_i = 1'b0, kmac_done_i = 1'b0, kmac_err_i = 1'b0;
    logic [TopCount*DW-1:0]    kmac_digest_i = '0;
    logic [DW-1:0]             exp_digest_o;
    logic                      exp_digest_vld_o;
    logic [TAW-1:0]            exp_digest_idx_o;
    logic                      rescan_req_i = 1'b0;
    logic                      busy_o, done_o, good_o, alert_o;

    rom_ctrl_scan_fsm #(.RomDepth(RomDepth), .TopCount(TopCount), .DataWidth(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .rom_select_o(rom_select_o),
        .kmac_vld_o(kmac_vld_o), .kmac_data_o(kmac_data_o), .kmac_last_o(kmac_last_o),
        .kmac_rdy_i(kmac_rdy_i), .kmac_done_i(kmac_done_i), .kmac_err_i(kmac_err_i),
        .kmac_digest_i(kmac_digest_i),
        .exp_digest_o(exp_digest_o), .exp_digest_vld_o(exp_digest_vld_o),
        .exp_digest_idx_o(exp_digest_idx_o),
        .rescan_req_i(rescan_req_i),
        .busy_o(busy_o), .done_o(done_o), .good_o(good_o), .alert_o(alert_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic last; logic [DW-1:0] data; } kw_t;
    typedef struct packed { logic [TAW-1:0] idx; logic [DW-1:0] data; } cw_t;

    kw_t                          kq[$];
    cw_t                          cq[$];
    kw_t                          mon_k;
    cw_t                          mon_c;
    logic [DW-1:0]                rom_mem [RomDepth];
    logic [TopCount-1:0][DW-1:0]  kdig;
    int                           n_vec = 0;
    int                           n_err = 0;
    int                           scan_end, scan_fire, stall_cnt;
    logic                         stall_q = 1'b0;
    logic [DW-1:0]                stall_data = '0;

    // ROM model: one-cycle read latency.
    always @(posedge clk_i) rom_data_i <= rom_mem[rom_addr_o];

    // Scoreboard monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk_i);
        if (rst_i) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                n_vec++;
                if (kmac_vld_o !== 1'b1 || kmac_data_o !== stall_data) begin
                    n_err++;
                    $display("FAIL kmac_hold: vld=%b data=%h, required vld=1 data=%h", kmac_vld_o, kmac_data_o, stall_data);
                end
            end
            if (kmac_vld_o && kmac_rdy_i) begin
                n_vec++;
                if (kq.size() == 0) begin
                    n_err++;
                    $display("FAIL kmac_extra: data=%h last=%b, required no transfer", kmac_data_o, kmac_last_o);
                end else begin
                    mon_k = kq.pop_front();
                    if ({kmac_last_o, kmac_data_o} !== mon_k) begin
                        n_err++;
                        $display("FAIL kmac_word: last=%b data=%h, required last=%b data=%h", kmac_last_o, kmac_data_o, mon_k.last, mon_k.data);
                    end
                end
            end
            if (kmac_vld_o && !kmac_rdy_i) stall_cnt++;
            stall_q    = kmac_vld_o && !kmac_rdy_i;
            stall_data = kmac_data_o;
            if (exp_digest_vld_o) begin
                n_vec++;
                if (cq.size() == 0) begin
                    n_err++;
                    $display("FAIL capture_extra: idx=%0d data=%h, required no capture", exp_digest_idx_o, exp_digest_o);
                end else begin
                    mon_c = cq.pop_front();
                    if ({exp_digest_idx_o, exp_digest_o} !== mon_c) begin
                        n_err++;
                        $display("FAIL capture: idx=%0d data=%h, required idx=%0d data=%h", exp_digest_idx_o, exp_digest_o, mon_c.idx, mon_c.data);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1; kmac_rdy_i = 1'b0; kmac_done_i = 1'b0; kmac_err_i = 1'b0;
        rescan_req_i = 1'b0; kmac_digest_i = '0; stall_cnt = 0;
        repeat (3) @(posedge clk_i);
        #1;
        kq.delete(); cq.delete();
        rst_i = 1'b0;
    endtask

    task automatic push_exp();
        for (int i = 0; i < TopStart; i++) kq.push_back({(i == TopStart-1), rom_mem[i]});
        for (int i = 0; i < TopCount; i++) cq.push_back({TAW'(i), rom_mem[TopStart+i]});
    endtask

    task automatic prep();
        for (int i = 0; i < RomDepth; i++) rom_mem[i] = $urandom;
        for (int i = 0; i < TopCount; i++) kdig[i] = rom_mem[TopStart+i];
        push_exp();
    endtask

    // mode 0: done arg cycles after last accept; 1: done with capture of idx arg; 2: done on first KMAC accept.
    task automatic run_scan(input int rdy_per, input int mode, input int arg, input logic err);
        int  c = 0;
        int  since = -1;
        bit  fired = 0;
        scan_fire = -1;
        while (c < 2000) begin
            kmac_done_i = 1'b0;
            kmac_err_i  = 1'b0;
            if (done_o || alert_o) break;
            kmac_rdy_i = (rdy_per <= 1) || (c % rdy_per == 0);
            if (since >= 0) since++;
            if (!fired && ((mode == 0 && since == arg) ||
                           (mode == 1 && exp_digest_vld_o && exp_digest_idx_o == TAW'(arg)) ||
                           (mode == 2 && kmac_vld_o && kmac_rdy_i))) begin
                kmac_done_i   = 1'b1;
                kmac_err_i    = err;
                kmac_digest_i = kdig;
                fired         = 1;
                scan_fire     = c;
            end
            @(negedge clk_i);
            if (kmac_vld_o && kmac_rdy_i && kmac_last_o) since = 0;
            @(posedge clk_i);
            #1;
            c++;
        end
        kmac_done_i = 1'b0;
        kmac_err_i  = 1'b0;
        scan_end    = c;
        if (c >= 2000) begin
            n_vec++; n_err++;
            $display("FAIL scan_timeout: no done/alert after %0d cycles, required completion", c);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_vec++;
        if ({rom_req_o, rom_select_o, kmac_vld_o, kmac_last_o, exp_digest_vld_o, busy_o, done_o, good_o, alert_o} !== 9'b010001000) begin
            n_err++;
            $display("FAIL reset_flags: got %b, required 010001000",
                {rom_req_o, rom_select_o, kmac_vld_o, kmac_last_o, exp_digest_vld_o, busy_o, done_o, good_o, alert_o});
        end
        n_vec++;
        if (rom_addr_o !== '0 || kmac_data_o !== '0 || exp_digest_o !== '0 || exp_digest_idx_o !== '0) begin
            n_err++;
            $display("FAIL reset_data: addr=%h kdata=%h exp=%h idx=%h, required all 0", rom_addr_o, kmac_data_o, exp_digest_o, exp_digest_idx_o);
        end
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        n_vec++;
        if (rom_req_o !== 1'b1 || rom_addr_o !== '0) begin
            n_err++;
            $display("FAIL first_req: req=%b addr=%0d, required req=1 addr=0", rom_req_o, rom_addr_o);
        end
    endtask

    task automatic test_good_scan();
        do_reset(); prep();
        run_scan(1, 0, 3, 1'b0);
        n_vec++;
        if ({done_o, good_o, rom_select_o, busy_o, alert_o} !== 5'b11000) begin
            n_err++;
            $display("FAIL good_scan: done/good/sel/busy/alert=%b, required 11000", {done_o, good_o, rom_select_o, busy_o, alert_o});
        end
        n_vec++;
        if (kq.size() != 0 || cq.size() != 0) begin
            n_err++;
            $display("FAIL good_scan_drain: kmac left=%0d captures left=%0d, required 0 0", kq.size(), cq.size());
        end
    endtask

    task automatic test_mismatch();
        do_reset(); prep();
        kdig[5] = kdig[5] ^ 32'h0000_0010;
        run_scan(1, 0, 3, 1'b0);
        n_vec++;
        if ({done_o, good_o, alert_o} !== 3'b100) begin
            n_err++;
            $display("FAIL mismatch: done/good/alert=%b, required 100", {done_o, good_o, alert_o});
        end
    endtask

    task automatic test_backpressure();
        do_reset(); prep();
        run_scan(3, 0, 3, 1'b0);
        n_vec++;
        if ({done_o, good_o} !== 2'b11 || kq.size() != 0 || stall_cnt == 0) begin
            n_err++;
            $display("FAIL backpressure: done/good=%b left=%0d stalls=%0d, required 11, 0, >0", {done_o, good_o}, kq.size(), stall_cnt);
        end
    endtask

    task automatic test_race();
        do_reset(); prep();
        run_scan(1, 1, TopCount-1, 1'b0);
        n_vec++;
        if ({done_o, good_o} !== 2'b11 || scan_end - scan_fire != TopCount + 1) begin
            n_err++;
            $display("FAIL race: done/good=%b latency=%0d, required 11 latency=%0d", {done_o, good_o}, scan_end - scan_fire, TopCount + 1);
        end
    endtask

    task automatic test_wait_rom();
        do_reset(); prep();
        run_scan(1, 1, 2, 1'b0);
        n_vec++;
        if ({done_o, good_o, alert_o} !== 3'b110 || cq.size() != 0) begin
            n_err++;
            $display("FAIL wait_rom: done/good/alert=%b left=%0d, required 110, 0", {done_o, good_o, alert_o}, cq.size());
        end
    endtask

    task automatic test_wait_kmac();
        do_reset(); prep();
        run_scan(1, 0, 20, 1'b0);
        n_vec++;
        if ({done_o, good_o} !== 2'b11 || scan_end - scan_fire != TopCount + 1) begin
            n_err++;
            $display("FAIL wait_kmac: done/good=%b latency=%0d, required 11 latency=%0d", {done_o, good_o}, scan_end - scan_fire, TopCount + 1);
        end
    endtask

    task automatic test_fault(input int mode, input logic err);
        do_reset(); prep();
        run_scan(1, mode, 3, err);
        n_vec++;
        if (alert_o !== 1'b1 || scan_end - scan_fire != 1) begin
            n_err++;
            $display("FAIL fault_alert(mode %0d): alert=%b delay=%0d, required 1 delay=1", mode, alert_o, scan_end - scan_fire);
        end
        repeat (5) begin
            @(negedge clk_i);
            n_vec++;
            if ({alert_o, done_o, good_o, rom_req_o, rom_select_o} !== 5'b10001) begin
                n_err++;
                $display("FAIL fault_sticky(mode %0d): alert/done/good/req/sel=%b, required 10001", mode, {alert_o, done_o, good_o, rom_req_o, rom_select_o});
            end
        end
    endtask

    task automatic test_rescan();
        do_reset(); prep();
        run_scan(1, 0, 3, 1'b0);
        n_vec++;
        if ({done_o, good_o} !== 2'b11) begin
            n_err++;
            $display("FAIL rescan_first: done/good=%b, required 11", {done_o, good_o});
        end
        push_exp();
        rescan_req_i = 1'b1;
        @(posedge clk_i); #1 rescan_req_i = 1'b0;
`ifdef ROM_CTRL_SCAN_RESCAN_EN
        @(negedge clk_i);
        n_vec++;
        if ({done_o, good_o, rom_select_o, rom_req_o} !== 4'b0011 || rom_addr_o !== '0) begin
            n_err++;
            $display("FAIL rescan_restart: done/good/sel/req=%b addr=%0d, required 0011 addr=0", {done_o, good_o, rom_select_o, rom_req_o}, rom_addr_o);
        end
        @(posedge clk_i); #1;
        run_scan(1, 0, 3, 1'b0);
        n_vec++;
        if ({done_o, good_o, alert_o} !== 3'b110 || kq.size() != 0 || cq.size() != 0) begin
            n_err++;
            $display("FAIL rescan_second: done/good/alert=%b left=%0d/%0d, required 110, 0/0", {done_o, good_o, alert_o}, kq.size(), cq.size());
        end
`else
        repeat (5) begin
            @(negedge clk_i);
            n_vec++;
            if ({done_o, good_o, rom_select_o, rom_req_o, busy_o} !== 5'b11000) begin
                n_err++;
                $display("FAIL rescan_ignored: done/good/sel/req/busy=%b, required 11000", {done_o, good_o, rom_select_o, rom_req_o, busy_o});
            end
        end
        kq.delete(); cq.delete();
`endif
    endtask

    initial begin
        for (int i = 0; i < RomDepth; i++) rom_mem[i] = '0;
        kdig = '0;
        test_reset();
        test_good_scan();
        test_mismatch();
        test_backpressure();
        test_race();
        test_wait_rom();
        test_wait_kmac();
        test_fault(2, 1'b0);
        test_fault(0, 1'b1);
        test_rescan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
